demux_out_serializer: RTL and testbench
=======================================

# demux_out_serializer

Downstream stage of the 512-to-1 mux / 1-to-512 demux I/O register chain: captures the 500-bit folded demux output word on request and streams it out LSB-first over a single-bit valid/ready link. Frees the pad ring from 500 parallel outputs, so large parallel results can be read through one serial pin. One capture is in flight at a time; an optional trailing even-parity bit protects each frame.

## Interface
- WIDTH, 500: captured word width (the folded demux output).
- CNT_W, 9: bit-counter width; must satisfy 2^CNT_W >= WIDTH.
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cap_req  input  1  capture request, sampled each cycle.
- par_in  input  WIDTH  parallel word to capture (demux output).
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  consumer accepts the bit this cycle.
- frame_start  output  1  high while bit 0 of a frame is presented.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse after the last bit is accepted.
- overrun  output  1  sticky: cap_req arrived while busy.

## Operation
- States: IDLE, SHIFT, PARITY (only with the parity macro), DONE.
- IDLE: cap_req=1 -> shadow <= par_in, cnt <= 0, par_acc <= 0, overrun <= 0, go to SHIFT.
- SHIFT: ser_valid=1, ser_out=shadow[0]. On ser_valid&&ser_ready: shadow >>= 1, par_acc ^= ser_out, cnt++. The handshake at cnt==WIDTH-1 goes to PARITY (macro defined) or DONE.
- PARITY: ser_valid=1, ser_out=par_acc (even parity over the WIDTH data bits). The handshake goes to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- ser_valid deassertion: ser_valid never drops while ser_ready is low. ser_out is stable until the handshake completes.
- frame_start = (state==SHIFT && cnt==0).
- busy = 1 in SHIFT, PARITY and DONE.
- cap_req while not IDLE: ignored, and overrun <= 1. overrun stays set until the next accepted capture.
- cap_req in the DONE cycle: ignored and flags overrun. The earliest accepted capture is the IDLE cycle after done.
- par_in is sampled only on the accepted capture edge. Later par_in changes do not affect the frame.
- Counter never wraps: cnt is held in range 0..WIDTH-1.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE. ser_out, ser_valid, frame_start, busy, done, overrun = 0. shadow, cnt, par_acc = 0.
- Reset mid-frame: the frame is aborted immediately, with no done pulse. After release the block is in IDLE.
- cap_req high at edge N -> ser_valid, frame_start and busy high from cycle N+1.
- With ser_ready held high: one bit per cycle. Data is WIDTH cycles, plus 1 with parity. done is high in cycle N+1+WIDTH (N+2+WIDTH with parity). busy is low the cycle after done.
- ser_ready low stalls the frame with no bit loss or duplication. Each stall cycle extends latency by 1.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output except ser_ready into the next state.

## Configuration
- DEMUX_SER_PARITY_EN defined: the PARITY state exists. Each frame is WIDTH+1 bits, and the last bit is the XOR of all data bits.
- DEMUX_SER_PARITY_EN undefined: no PARITY state and no par_acc logic. Each frame is exactly WIDTH bits, and done follows the last data bit.

## Test plan
- Reset, then idle for 10 cycles -> all outputs 0, busy=0.
- par_in = {499'b0, 1'b1}, cap_req pulse, ser_ready=1 -> bits are 1 then 499 zeros. done 501 cycles after cap_req (502 with parity, parity bit = 1).
- par_in = all ones, ser_ready toggling 1/0 every cycle -> exactly 500 ones are accepted, and ser_out is stable during stalls. The parity bit is 0 (500 is even).
- cap_req at data bit 200, with par_in changed afterwards -> overrun=1, and the frame completes with the original word. The next accepted cap_req clears overrun.
- rst_n low at bit 300 -> outputs 0 immediately, with no done pulse. A fresh capture afterwards streams the correct word from bit 0.
- cap_req in the done cycle -> ignored and overrun=1. cap_req on the following cycle is accepted, and frame_start is seen 1 cycle later.

Source files
------------

// File: rtl/demux_out_serializer.sv
// Serializer for the folded demux output word: captures on cap_req, streams LSB-first.
// Optional trailing even-parity bit when DEMUX_SER_PARITY_EN is defined.
module demux_out_serializer #(
   parameter int WIDTH = 500,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap_req,
   input  logic [WIDTH-1:0] par_in,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             frame_start,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

`ifdef DEMUX_SER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shadow_q, shadow_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               overrun_q, overrun_d;
`ifdef DEMUX_SER_PARITY_EN
   logic               par_acc_q, par_acc_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
`ifdef DEMUX_SER_PARITY_EN
         par_acc_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
`ifdef DEMUX_SER_PARITY_EN
         par_acc_q <= par_acc_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;
`ifdef DEMUX_SER_PARITY_EN
      par_acc_d = par_acc_q;
`endif
      // Any request outside IDLE is dropped but remembered.
      if (cap_req && state_q != IDLE) begin
         overrun_d = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (cap_req) begin
               shadow_d  = par_in;
               cnt_d     = '0;
               overrun_d = 1'b0;
`ifdef DEMUX_SER_PARITY_EN
               par_acc_d = 1'b0;
`endif
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               shadow_d = shadow_q >> 1;
`ifdef DEMUX_SER_PARITY_EN
               par_acc_d = par_acc_q ^ shadow_q[0];
`endif
               if (cnt_q == LAST) begin
`ifdef DEMUX_SER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = DONE;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
`ifdef DEMUX_SER_PARITY_EN
         PARITY: begin
            if (ser_ready) begin
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      ser_out   = 1'b0;
      ser_valid = 1'b0;
      unique case (state_q)
         SHIFT: begin
            ser_out   = shadow_q[0];
            ser_valid = 1'b1;
         end
`ifdef DEMUX_SER_PARITY_EN
         PARITY: begin
            ser_out   = par_acc_q;
            ser_valid = 1'b1;
         end
`endif
         default: begin
            ser_out   = 1'b0;
            ser_valid = 1'b0;
         end
      endcase
   end

   assign frame_start = (state_q == SHIFT) && (cnt_q == '0);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_demux_out_serializer.sv
// Randomized bench for demux_out_serializer against a queue-based frame model.
// Honors DEMUX_SER_PARITY_EN the same way as the design.
module tb_demux_out_serializer;
   localparam int W     = 500;
   localparam int CNT_W = 9;
`ifdef DEMUX_SER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FL = W + PB;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cap_req;
   logic [W-1:0] par_in;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_ready;
   logic         frame_start;
   logic         busy;
   logic         done;
   logic         overrun;

   demux_out_serializer #(.WIDTH(W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cap_req    (cap_req),
      .par_in     (par_in),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .ser_ready  (ser_ready),
      .frame_start(frame_start),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Model: bits still owed to the consumer, phase 0 idle / 1 stream / 2 done.
   bit exp_q[$];
   int ph        = 0;
   bit m_ovr     = 1'b0;
   int cap_edge  = 0;
   int done_edge = 0;
   int n_hs      = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] w;
      for (int i = 0; i < W; i++) w[i] = 1'($urandom);
      return w;
   endfunction

   function automatic logic rdy_of(input int mode);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ~cyc[0];
      return 1'($urandom);
   endfunction

   task automatic check_outs();
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("done", 32'(done), 32'(ph == 2));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("ser_valid", 32'(ser_valid), 32'(exp_q.size() != 0));
      chk("frame_start", 32'(frame_start),
          32'(ph == 1 && exp_q.size() == FL));
      if (exp_q.size() != 0) chk("ser_out", 32'(ser_out), 32'(exp_q[0]));
   endtask

   task automatic cycle(input logic cr, input logic rdy,
                        input logic [W-1:0] pin);
      cap_req   = cr;
      ser_ready = rdy;
      par_in    = pin;
      check_outs();
      if (ph == 2) done_edge = cyc;
      case (ph)
         0: begin
            if (cr) begin
               exp_q.delete();
               for (int i = 0; i < W; i++) exp_q.push_back(pin[i]);
               if (PB == 1) exp_q.push_back(^pin);
               m_ovr    = 1'b0;
               ph       = 1;
               n_hs     = 0;
               cap_edge = cyc + 1;
            end
         end
         1: begin
            if (cr) m_ovr = 1'b1;
            if (rdy) begin
               void'(exp_q.pop_front());
               n_hs++;
               if (exp_q.size() == 0) ph = 2;
            end
         end
         default: begin
            if (cr) m_ovr = 1'b1;
            ph = 0;
         end
      endcase
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic run_to_idle(input int mode);
      int n = 0;
      while (ph != 0 && n < 4000) begin
         cycle(1'b0, rdy_of(mode), rnd_word());
         n++;
      end
      chk("idle_timeout", 32'(ph), 32'd0);
   endtask

   task automatic run_to_left(input int mode, input int left);
      int n = 0;
      while (!(ph == 1 && exp_q.size() == left) && n < 4000) begin
         cycle(1'b0, rdy_of(mode), rnd_word());
         n++;
      end
      chk("left_timeout", 32'(exp_q.size()), 32'(left));
   endtask

   task automatic run_to_done(input int mode);
      int n = 0;
      while (ph != 2 && n < 4000) begin
         cycle(1'b0, rdy_of(mode), rnd_word());
         n++;
      end
      chk("done_timeout", 32'(ph), 32'd2);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_ser_out", 32'(ser_out), 32'd0);
      chk("rst_ser_valid", 32'(ser_valid), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      exp_q.delete();
      ph        = 0;
      m_ovr     = 1'b0;
      cap_req   = 1'b0;
      ser_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      cyc += 2;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] w;
      rst_n     = 1'b0;
      cap_req   = 1'b0;
      ser_ready = 1'b0;
      par_in    = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) cycle(1'b0, 1'b0, '0);

      // Single set LSB, ready held high, latency from capture edge to done.
      w    = '0;
      w[0] = 1'b1;
      cycle(1'b1, 1'b1, w);
      run_to_idle(0);
      chk("latency", 32'(done_edge - cap_edge), 32'(W + PB));
      chk("nbits_onehot", 32'(n_hs), 32'(FL));

      // All ones with ready toggling.
      cycle(1'b1, 1'b1, '1);
      run_to_idle(1);
      chk("nbits_ones", 32'(n_hs), 32'(FL));

      // Late request mid-frame sets overrun, original word still streams.
      cycle(1'b1, 1'b1, rnd_word());
      run_to_left(2, FL - 200);
      cycle(1'b1, 1'b1, rnd_word());
      chk("ovr_set", 32'(overrun), 32'd1);
      run_to_idle(2);
      cycle(1'b0, 1'b0, rnd_word());
      cycle(1'b1, 1'b1, rnd_word());
      chk("ovr_clr", 32'(overrun), 32'd0);
      run_to_idle(0);

      // Reset in the middle of a frame, then a fresh capture.
      cycle(1'b1, 1'b1, rnd_word());
      run_to_left(0, FL - 300);
      do_reset();
      repeat (3) cycle(1'b0, 1'b1, rnd_word());
      cycle(1'b1, 1'b1, rnd_word());
      run_to_idle(2);

      // Request during done is dropped, the next cycle's request is taken.
      cycle(1'b1, 1'b1, rnd_word());
      run_to_done(0);
      cycle(1'b1, 1'b1, rnd_word());
      chk("done_req_ovr", 32'(overrun), 32'd1);
      chk("done_req_busy", 32'(busy), 32'd0);
      cycle(1'b1, 1'b1, rnd_word());
      chk("fs_after_done", 32'(frame_start), 32'd1);
      run_to_idle(0);

      // Free-running random traffic.
      for (int i = 0; i < 4000; i++) begin
         cycle(logic'($urandom_range(0, 60) == 0), rdy_of(2), rnd_word());
      end
      run_to_idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
